// File: rtl/alu4_chain_seq.sv
// rtl/alu4_chain_seq.sv - nibble-serial sequencer driving an external combinational alu4 stage
//
// Accepts one 4*NIB-bit operation over in_valid/in_ready, feeds it to alu4
// one nibble per clock (least significant first) with the carry chained
// from alu_c2 back into alu_c1, then holds the assembled result on
// res_valid/res_ready.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid, in_ready          operation request handshake
//   op_i, a_i, b_i, cin_i       opcode, operands, carry into nibble 0
//   alu_a, alu_b, alu_c1, alu_o nibble operands, carry and opcode to alu4
//   alu_s, alu_c2               nibble sum and carry from alu4
//   res_valid, res_ready        result handshake
//   res_o, cout_o               assembled result, carry out of top nibble
module alu4_chain_seq #(
    parameter int NIB = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op_i,
    input  logic [4*NIB-1:0] a_i,
    input  logic [4*NIB-1:0] b_i,
    input  logic             cin_i,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_c1,
    output logic [1:0]       alu_o,
    input  logic [3:0]       alu_s,
    input  logic             alu_c2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [4*NIB-1:0] res_o,
    output logic             cout_o
);

    localparam int IW = $clog2(NIB);
    localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [NIB-1:0][3:0]    a_q, a_d;
    logic [NIB-1:0][3:0]    b_q, b_d;
    logic [NIB-1:0][3:0]    res_q, res_d;
    logic [1:0]             op_q, op_d;
    logic                   carry_q, carry_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            op_q    <= op_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        op_d    = op_q;
        carry_d = carry_q;
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_c1  = 1'b0;
        alu_o   = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    op_d    = op_i;
                    carry_d = cin_i;
                    idx_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                alu_a  = a_q[idx_q];
                alu_b  = b_q[idx_q];
                alu_c1 = carry_q;
                alu_o  = op_q;
                // The carry register doubles as the chain link: it holds the
                // carry into the current nibble and, after the last nibble,
                // the final carry out.
                res_d[idx_q] = alu_s;
                carry_d      = alu_c2;
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign res_valid = (state_q == ST_DONE);
    // Result is shown only while valid so partial sums from RUN never leak out.
    assign res_o     = res_valid ? res_q : '0;
    assign cout_o    = res_valid ? carry_q : 1'b0;

endmodule

// File: tb/tb_alu4_chain_seq.sv
// tb/tb_alu4_chain_seq.sv - self-checking bench for alu4_chain_seq with a stand-in adder alu4
module tb_alu4_chain_seq;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   op_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_c1;
    logic [1:0]   alu_o;
    logic [3:0]   alu_s;
    logic         alu_c2;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_o;
    logic         cout_o;

    always #5 clk = ~clk;

    alu4_chain_seq #(.NIB(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_i      (op_i),
        .a_i       (a_i),
        .b_i       (b_i),
        .cin_i     (cin_i),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c1    (alu_c1),
        .alu_o     (alu_o),
        .alu_s     (alu_s),
        .alu_c2    (alu_c2),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_o     (res_o),
        .cout_o    (cout_o)
    );

    // Stand-in alu4: a plain 4-bit adder whatever the opcode.
    always_comb begin
        {alu_c2, alu_s} = 5'(alu_a) + 5'(alu_b) + 5'(alu_c1);
    end

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full-width reference: W-bit sum with the carry in bit W.
    function automatic logic [63:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        return 64'(a) + 64'(b) + 64'(cin);
    endfunction

    // Carry into nibble k = carry out of the k low nibbles added together.
    function automatic logic [63:0] ref_cin_nib(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic cin, input int k);
        logic [63:0] mask;
        mask = (64'd1 << (4 * k)) - 64'd1;
        return ((64'(a) & mask) + (64'(b) & mask) + 64'(cin)) >> (4 * k);
    endfunction

    task automatic drive_after(input logic keep_valid, input logic [W-1:0] na, input logic [W-1:0] nb);
        in_valid = keep_valid;
        a_i      = keep_valid ? na : W'($urandom);
        b_i      = keep_valid ? nb : W'($urandom);
        cin_i    = keep_valid ? 1'b0 : 1'($urandom);
        op_i     = keep_valid ? 2'b00 : 2'($urandom);
    endtask

    // Called #1 after an edge with the block expected idle. Runs one
    // operation end to end, holding res_ready low for 'hold' cycles.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                         input logic [1:0] op, input int hold, input logic keep_valid,
                         input logic [W-1:0] na, input logic [W-1:0] nb, output int t_acc);
        logic [63:0] s;
        int n;
        s         = ref_sum(a, b, cin);
        a_i       = a;
        b_i       = b;
        cin_i     = cin;
        op_i      = op;
        in_valid  = 1'b1;
        res_ready = 1'b1;
        t_acc     = -1;
        n         = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
            return;
        end
        @(posedge clk); #1;
        t_acc = edge_cnt;
        drive_after(keep_valid, na, nb);
        for (int k = 0; k < NIB; k++) begin
            chk($sformatf("run%0d_alu_a", k), 64'(alu_a), 64'(a[4*k +: 4]));
            chk($sformatf("run%0d_alu_b", k), 64'(alu_b), 64'(b[4*k +: 4]));
            chk($sformatf("run%0d_alu_c1", k), 64'(alu_c1), ref_cin_nib(a, b, cin, k));
            chk($sformatf("run%0d_alu_o", k), 64'(alu_o), 64'(op));
            chk($sformatf("run%0d_busy", k), 64'({res_valid, in_ready}), 64'd0);
            @(posedge clk); #1;
        end
        res_ready = (hold > 0) ? 1'b0 : 1'b1;
        chk("done_valid", 64'(res_valid), 64'd1);
        chk("done_res", 64'(res_o), s & ((64'd1 << W) - 64'd1));
        chk("done_cout", 64'(cout_o), (s >> W) & 64'd1);
        chk("done_in_ready", 64'(in_ready), 64'd0);
        chk("done_alu_idle", 64'({alu_a, alu_b, alu_c1, alu_o}), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("hold_valid", 64'(res_valid), 64'd1);
            chk("hold_res", 64'(res_o), s & ((64'd1 << W) - 64'd1));
            chk("hold_cout", 64'(cout_o), (s >> W) & 64'd1);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
            if (h == hold - 1) res_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("post_valid", 64'(res_valid), 64'd0);
        chk("post_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int ta, tb2;
        logic [W-1:0] ra, rb;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        res_ready = 1'b1;
        a_i = '0; b_i = '0; cin_i = 1'b0; op_i = 2'b00;

        // Reset held for two edges with random inputs.
        for (int i = 0; i < 2; i++) begin
            in_valid  = 1'($urandom);
            res_ready = 1'($urandom);
            a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom); op_i = 2'($urandom);
            @(posedge clk); #1;
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        res_ready = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_o", 64'(res_o), 64'd0);
        chk("rst_cout", 64'(cout_o), 64'd0);
        chk("rst_alu", 64'({alu_a, alu_b, alu_c1, alu_o}), 64'd0);
        @(posedge clk); #1;
        chk("idle_in_ready", 64'(in_ready), 64'd1);
        chk("idle_res_valid", 64'(res_valid), 64'd0);

        // Directed operations.
        do_op(16'h1234, 16'h4321, 1'b0, 2'b00, 0, 1'b0, '0, '0, ta);
        do_op(16'hFFFF, 16'h0001, 1'b0, 2'b00, 0, 1'b0, '0, '0, ta);
        do_op(16'hFFFF, 16'h0000, 1'b1, 2'b00, 0, 1'b0, '0, '0, ta);

        // Backpressure with a new request held pending; it must be taken only after the handshake.
        do_op(16'h1234, 16'h4321, 1'b0, 2'b00, 3, 1'b1, 16'hA5C3, 16'h1E2F, ta);
        do_op(16'hA5C3, 16'h1E2F, 1'b0, 2'b00, 0, 1'b0, '0, '0, tb2);
        chk("bp_next_accept_gap", 64'(tb2 - ta), 64'(NIB + 2 + 3));

        // Reset in the middle of a run.
        a_i = 16'h1234; b_i = 16'h4321; cin_i = 1'b0; op_i = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_alu", 64'({alu_a, alu_b, alu_c1, alu_o}), 64'd0);
        for (int i = 0; i < NIB + 2; i++) begin
            chk("midrst_no_valid", 64'(res_valid), 64'd0);
            @(posedge clk); #1;
        end
        do_op(16'h0F0F, 16'h0101, 1'b0, 2'b00, 0, 1'b0, '0, '0, ta);

        // Back-to-back with in_valid held high.
        ra = W'($urandom); rb = W'($urandom);
        do_op(16'h8001, 16'h7FFF, 1'b1, 2'b00, 0, 1'b1, ra, rb, ta);
        do_op(ra, rb, 1'b0, 2'b00, 0, 1'b0, '0, '0, tb2);
        chk("b2b_accept_gap", 64'(tb2 - ta), 64'(NIB + 2));

        // Random operations, random opcodes and random backpressure.
        for (int i = 0; i < 24; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), 2'($urandom),
                  int'($urandom_range(0, 2)), 1'b0, '0, '0, ta);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
